vote_tally: RTL

Parametrised successor to the team's four-candidate voting machine. Supports N candidates, configurable counter width, saturating per-candidate tallies and a total-ballot counter. A poll-session FSM (IDLE/OPEN/TALLY/DONE) gates ballot acceptance and rejects malformed ballots. Winner selection is a sequential one-candidate-per-cycle scan with tie detection, replacing the combinational compare tree.

---
 rtl/vote_tally.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vote_tally.sv
// N-candidate ballot tally with saturating counters, poll-session FSM and a
// sequential winner scan (one candidate per cycle, lowest index wins ties).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no session; counters hold, waiting for open_poll
// S_OPEN  | accepting ballots; close_poll moves to the tally scan
// S_TALLY | scanning count[0..N_CAND-1], one index per cycle
// S_DONE  | win/tie/win_count valid; open_poll starts a new session
module vote_tally #(
    parameter int  N_CAND = 4,
    parameter int  CNT_W  = 21,
    localparam int IDX_W  = $clog2(N_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             open_poll,
    input  logic             close_poll,
    input  logic             vote_valid,
    input  logic [N_CAND-1:0] vote,
    output logic             vote_ready,
    output logic             vote_err,
    output logic [CNT_W-1:0] total,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count,
    output logic             done,
    output logic [IDX_W-1:0] win,
    output logic             tie,
    output logic [CNT_W-1:0] win_count
);

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_TALLY, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(N_CAND - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt [N_CAND];
    logic [IDX_W-1:0] scan;
    logic [CNT_W-1:0] best, best_nxt;
    logic [IDX_W-1:0] win_nxt;
    logic             tie_nxt;
    logic [CNT_W-1:0] cnt_scan, rd_sel;
    logic             accept, one_hot, start, scan_last;

    assign one_hot    = (vote != '0) && ((vote & (vote - N_CAND'(1))) == '0);
    assign accept     = (state == S_OPEN) && vote_valid;
    assign start      = ((state == S_IDLE) || (state == S_DONE)) && open_poll;
    assign scan_last  = (scan == SCAN_LAST);
    assign vote_ready = (state == S_OPEN);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (open_poll)  state_nxt = S_OPEN;
            S_OPEN:  if (close_poll) state_nxt = S_TALLY;
            S_TALLY: if (scan_last)  state_nxt = S_DONE;
            S_DONE:  if (open_poll)  state_nxt = S_OPEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared index muxes: one for the scan, one for the registered readout.
    always_comb begin
        cnt_scan = '0;
        rd_sel   = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (scan == IDX_W'(i))   cnt_scan = cnt[i];
            if (rd_idx == IDX_W'(i)) rd_sel   = cnt[i];
        end
    end

    always_comb begin
        best_nxt = best;
        win_nxt  = win;
        tie_nxt  = tie;
        if (scan == '0) begin
            best_nxt = cnt_scan;
            win_nxt  = '0;
            tie_nxt  = 1'b0;
        end else if (cnt_scan > best) begin
            best_nxt = cnt_scan;
            win_nxt  = scan;
            tie_nxt  = 1'b0;
        end else if (cnt_scan == best) begin
            tie_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
            total     <= '0;
            vote_err  <= 1'b0;
            rd_count  <= '0;
            scan      <= '0;
            best      <= '0;
            win       <= '0;
            tie       <= 1'b0;
            win_count <= '0;
        end else begin
            vote_err <= accept && !one_hot;
            rd_count <= rd_sel;
            if (start) begin
                for (int i = 0; i < N_CAND; i++) cnt[i] <= '0;
                total     <= '0;
                scan      <= '0;
                best      <= '0;
                win       <= '0;
                tie       <= 1'b0;
                win_count <= '0;
            end else if (accept && one_hot) begin
                for (int i = 0; i < N_CAND; i++) begin
                    if (vote[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
                end
                if (total != CNT_MAX) total <= total + 1'b1;
            end else if (state == S_TALLY) begin
                best <= best_nxt;
                win  <= win_nxt;
                tie  <= tie_nxt;
                scan <= scan_last ? '0 : scan + 1'b1;
                if (scan_last) win_count <= best_nxt;
            end
        end
    end

endmodule
